// File: rtl/shift_normalizer_pkg.sv
// Shared encodings for the normalizer: FSM state codes and shifter op codes.
// The shifter op codes match the datapath shifter's existing interface.
package shift_normalizer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR1 = 2'b11;

endpackage

// File: rtl/shift_normalizer_shifter.sv
// Single-bit shifter shared with the datapath: pass, logical left/right,
// or arithmetic right by one bit, selected by a two-bit op code.
module shift_normalizer_shifter
    import shift_normalizer_pkg::*;
#(
    parameter int K = 16
) (
    input  logic [K-1:0] a,
    input  logic [1:0]   shift,
    output logic [K-1:0] y
);

    always_comb begin
        y = a;
        case (shift)
            SH_NONE: y = a;
            SH_LSL:  y = {a[K-2:0], 1'b0};
            SH_LSR:  y = {1'b0, a[K-1:1]};
            SH_ASR1: y = {a[K-1], a[K-1:1]};
            default: y = a;
        endcase
    end

endmodule

// File: rtl/shift_normalizer.sv
// Iterative left-normalizer: shifts one bit per clock until the MSB is set,
// reporting the leading-zero count, the normalized value and a zero flag.
module shift_normalizer
    import shift_normalizer_pkg::*;
#(
    parameter int K  = 16,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [K-1:0]  in,
    output logic [K-1:0]  out,
    output logic [CW-1:0] count,
    output logic          zero,
    output logic          busy,
    output logic          done
);

    logic [1:0]    state;
    logic [K-1:0]  work;
    logic [K-1:0]  work_shl;
    logic [CW-1:0] cnt;
    logic          zero_r;
    logic          accept;

    shift_normalizer_shifter #(
        .K(K)
    ) u_shifter (
        .a    (work),
        .shift(SH_LSL),
        .y    (work_shl)
    );

    assign accept = ((state == ST_IDLE) || (state == ST_DONE)) && start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            work   <= '0;
            cnt    <= '0;
            zero_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        zero_r <= (in == '0);
                        if (in == '0) begin
                            // Zero never terminates by shifting, so report K directly.
                            work  <= '0;
                            cnt   <= CW'(K);
                            state <= ST_DONE;
                        end else begin
                            work  <= in;
                            cnt   <= '0;
                            state <= in[K-1] ? ST_DONE : ST_SHIFT;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    // Exit when the bit about to land in the MSB is set.
                    work <= work_shl;
                    cnt  <= cnt + CW'(1);
                    if (work[K-2]) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out   = work;
    assign count = cnt;
    assign zero  = zero_r;
    assign busy  = (state == ST_SHIFT);
    assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed bench for shift_normalizer: reset, latency, zero input,
// ignored mid-shift start, back-to-back accept and reset abort.
module tb_shift_normalizer;

    localparam int K  = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [K-1:0]  in;
    logic [K-1:0]  out;
    logic [CW-1:0] count;
    logic          zero;
    logic          busy;
    logic          done;

    int n_assert = 0;
    int n_fail   = 0;

    shift_normalizer #(
        .K (K),
        .CW(CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .in   (in),
        .out  (out),
        .count(count),
        .zero (zero),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done, counting busy cycles seen on the way.
    task automatic wait_done(output int busy_cyc, output bit got);
        busy_cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_cyc++;
            tick();
        end
    endtask

    task automatic run(input string tag, input logic [K-1:0] val, input int exp_busy,
                       input logic [CW-1:0] exp_cnt, input logic [K-1:0] exp_out,
                       input logic exp_zero);
        int  bc;
        bit  got;
        in    = val;
        start = 1'b1;
        tick();
        start = 1'b0;
        in    = 16'hDEAD;
        wait_done(bc, got);
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
        check({tag, "_count"}, 32'(count), 32'(exp_cnt));
        check({tag, "_out"}, 32'(out), 32'(exp_out));
        check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_out_held"}, 32'(out), 32'(exp_out));
        check({tag, "_count_held"}, 32'(count), 32'(exp_cnt));
    endtask

    initial begin
        int  bc;
        bit  got;
        bit  saw_done;

        reset = 1'b1;
        start = 1'b1;
        in    = 16'h8000;
        tick();
        tick();
        check("rst_done_during", 32'(done), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("rst_out", 32'(out), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        run("msb_set", 16'h8000, 0, 5'd0, 16'h8000, 1'b0);
        run("one", 16'h0001, 15, 5'd15, 16'h8000, 1'b0);
        run("a50", 16'h0A50, 4, 5'd4, 16'hA500, 1'b0);
        run("zeroin", 16'h0000, 0, 5'd16, 16'h0000, 1'b1);

        // Start pulsed mid-shift must be ignored; then back-to-back accept in DONE.
        in    = 16'h00F0;
        start = 1'b1;
        tick();
        start = 1'b0;
        in    = 16'h1234;
        tick();
        tick();
        in    = 16'hFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        in    = 16'h1234;
        wait_done(bc, got);
        check("ign_done_seen", 32'(got), 32'd1);
        check("ign_count", 32'(count), 32'd8);
        check("ign_out", 32'(out), 32'hF000);
        in    = 16'h4000;
        start = 1'b1;
        tick();
        start = 1'b0;
        in    = 16'h1234;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done_low", 32'(done), 32'd0);
        tick();
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_count", 32'(count), 32'd1);
        check("b2b_out", 32'(out), 32'h8000);
        check("b2b_zero", 32'(zero), 32'd0);
        tick();

        // Reset on the third SHIFT cycle aborts without a done pulse.
        in    = 16'h0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_out", 32'(out), 32'd0);
        check("abort_count", 32'(count), 32'd0);
        check("abort_zero", 32'(zero), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        check("abort_quiet", 32'(saw_done), 32'd0);

        run("after_abort", 16'h2000, 2, 5'd2, 16'h8000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
